// File: rtl/apb_wait_slave_pkg.sv
// apb_wait_slave_pkg: shared FSM state, register offsets and address decode helper
package apb_wait_slave_pkg;
  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  localparam logic [11:0] OFF_WAIT = 12'hFF8;
  localparam logic [11:0] OFF_ID = 12'hFFC;
  function automatic logic offset_err(input logic [11:0] off, input logic wr, input int depth);
    return off[1:0] != 2'b00 || ({20'd0, off} >= 32'(depth * 4) && off != OFF_WAIT && off != OFF_ID) || (wr && off == OFF_ID);
  endfunction
endpackage

// File: rtl/apb_word_ram.sv
// apb_word_ram: word storage with one enabled registered read port and one write port
module apb_word_ram #(
  parameter int DEPTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // read data is held between enabled reads so it survives the wait states
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB3 completer with word storage, programmable wait states and protocol checking
module apb_wait_slave
  import apb_wait_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter logic [3:0] WAIT_RST = 4'd2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA2B0_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  proto_err_o
);
  localparam int AW = $clog2(DEPTH);
  state_t state_q;
  logic [3:0] wait_q, cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, ram_q;
  logic write_q, err_q, mem_q, proto_q;
  logic [11:0] off, off_q;
  logic setup, err, is_mem, done, changed;
  assign off = paddr_i[11:0];
  assign off_q = addr_q[11:0];
  assign err = offset_err(off, pwrite_i, DEPTH);
  assign is_mem = {20'd0, off} < 32'(DEPTH * 4);
  assign setup = state_q == S_IDLE && psel_i && !penable_i;
  assign pready_o = state_q == S_ACCESS && cnt_q == 4'd0;
  assign done = pready_o && psel_i && penable_i;
  assign changed = paddr_i != addr_q || pwrite_i != write_q || pwdata_i != wdata_q;
  assign prdata_o = pready_o && !write_q && !err_q ? (mem_q ? ram_q : rdata_q) : '0;
  assign pslverr_o = pready_o && err_q;
  assign proto_err_o = proto_q;
  apb_word_ram #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk),
    .rd_en(setup && is_mem && !err),
    .rd_addr(off[AW+1:2]),
    .rd_data(ram_q),
    .wr_en(done && write_q && !err_q && mem_q),
    .wr_addr(off_q[AW+1:2]),
    .wr_data(wdata_q)
  );
  // transfer FSM: latch the request at SETUP, count wait states, commit or abort in ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q <= WAIT_RST;
      cnt_q <= 4'd0;
      proto_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (setup) begin
        state_q <= S_ACCESS;
        addr_q <= paddr_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        err_q <= err;
        mem_q <= is_mem;
        cnt_q <= wait_q;
        rdata_q <= err ? '0 : (off == OFF_ID ? ID_VALUE : DATA_WIDTH'(wait_q));
      end else if (psel_i && penable_i) proto_q <= 1'b1;
    end else if (!psel_i) begin
      proto_q <= 1'b1;
      state_q <= S_IDLE;
    end else begin
      if (changed) proto_q <= 1'b1;
      if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (done) begin
        state_q <= S_IDLE;
        if (write_q && !err_q && off_q == OFF_WAIT) wait_q <= wdata_q[3:0];
      end
    end
  end
endmodule

// File: tb/tb_apb_wait_slave.sv
// tb_apb_wait_slave: randomized APB transfers checked every cycle against a transaction-level model
module tb_apb_wait_slave;
  localparam int DEPTH = 64;
  localparam logic [31:0] ID = 32'hA2B0_0001;
  localparam logic [31:0] BASE = 32'h0001_F000;
  logic clk = 0, rst = 1, psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0, prdata_o;
  logic pready_o, pslverr_o, proto_err_o;
  logic exp_pready = 0, exp_pslverr = 0, exp_proto = 0, chk_en = 0;
  logic [31:0] exp_prdata = 0;
  logic [31:0] mdl_mem [DEPTH];
  logic [3:0] mdl_wait = 4'd2;
  int checks = 0, failures = 0;
  apb_wait_slave dut (
    .clk(clk), .rst(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .proto_err_o(proto_err_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("pready", {31'd0, pready_o}, {31'd0, exp_pready});
    check("pslverr", {31'd0, pslverr_o}, {31'd0, exp_pslverr});
    check("prdata", prdata_o, exp_prdata);
    check("proto_err", {31'd0, proto_err_o}, {31'd0, exp_proto});
  end
  task automatic idle_exp();
    exp_pready = 0;
    exp_pslverr = 0;
    exp_prdata = 0;
  endtask
  task automatic xfer(input logic wr, input logic [11:0] off, input logic [31:0] data,
                      output logic [31:0] rd, output logic er, output int n);
    logic e;
    logic [31:0] v;
    int w;
    e = off[1:0] != 0 || !(off < DEPTH * 4 || off == 12'hFF8 || off == 12'hFFC) || (wr && off == 12'hFFC);
    v = (e || wr) ? 32'd0 : off == 12'hFF8 ? {28'd0, mdl_wait} : off == 12'hFFC ? ID : mdl_mem[off[7:2]];
    w = mdl_wait;
    rd = 0;
    er = 0;
    psel = 1; penable = 0; pwrite = wr; paddr = BASE | {20'd0, off}; pwdata = data;
    idle_exp();
    @(posedge clk); #1;
    penable = 1;
    n = 0;
    forever begin
      exp_pready = n == w;
      exp_pslverr = n == w && e;
      exp_prdata = n == w ? v : 32'd0;
      @(negedge clk);
      if (pready_o) begin
        rd = prdata_o;
        er = pslverr_o;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 40) begin
        check("access_timeout", n, w);
        break;
      end
    end
    @(posedge clk); #1;
    if (wr && !e) begin
      if (off == 12'hFF8) mdl_wait = data[3:0];
      else mdl_mem[off[7:2]] = data;
    end
    psel = 0; penable = 0;
    idle_exp();
    n++;
  endtask
  initial begin
    logic [31:0] rd, old, d;
    logic er, wr;
    logic [11:0] off;
    int n;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 0;
    xfer(0, 12'hFFC, 0, rd, er, n);
    check("t1_cycles", n, 3);
    check("t1_id", rd, 32'hA2B0_0001);
    check("t1_err", {31'd0, er}, 0);
    xfer(1, 12'hFF8, 0, rd, er, n);
    for (int i = 0; i < DEPTH; i++) xfer(1, 12'(i * 4), $urandom, rd, er, n);
    xfer(1, 12'h010, 32'h1234_5678, rd, er, n);
    check("t2_wr_cycles", n, 1);
    xfer(0, 12'h010, 0, rd, er, n);
    check("t2_rd_cycles", n, 1);
    check("t2_data", rd, 32'h1234_5678);
    xfer(1, 12'hFF8, 32'hF, rd, er, n);
    xfer(0, 12'h010, 0, rd, er, n);
    check("t3_cycles", n, 16);
    check("t3_data", rd, 32'h1234_5678);
    xfer(0, 12'h013, 0, rd, er, n);
    check("t4_misalign_err", {31'd0, er}, 1);
    check("t4_misalign_data", rd, 0);
    xfer(1, 12'hFFC, 32'h5555_AAAA, rd, er, n);
    check("t4_idwr_err", {31'd0, er}, 1);
    xfer(0, 12'(DEPTH * 4), 0, rd, er, n);
    check("t4_range_err", {31'd0, er}, 1);
    check("t4_range_data", rd, 0);
    xfer(0, 12'h010, 0, rd, er, n);
    check("t4_mem_kept", rd, 32'h1234_5678);
    xfer(0, 12'hFFC, 0, rd, er, n);
    check("t4_id_kept", rd, ID);
    for (int i = 0; i < 250; i++) begin
      wr = 1'($urandom);
      d = $urandom;
      case ($urandom_range(0, 9))
        6: off = 12'hFF8;
        7: off = 12'hFFC;
        8: off = 12'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        9: off = 12'(DEPTH * 4 + 4 * $urandom_range(0, 957));
        default: off = 12'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      xfer(wr, off, d, rd, er, n);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    xfer(1, 12'hFF8, 2, rd, er, n);
    old = mdl_mem[8];
    psel = 1; penable = 0; pwrite = 1; paddr = BASE | 32'h020; pwdata = 32'hDEAD;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(posedge clk); #1;
    exp_proto = 1;
    @(posedge clk); #1;
    xfer(0, 12'h020, 0, rd, er, n);
    check("t5_old_value", rd, old);
    check("t5_proto_sticky", {31'd0, proto_err_o}, 1);
    xfer(1, 12'hFF8, 5, rd, er, n);
    old = mdl_mem[8];
    psel = 1; penable = 0; pwrite = 1; paddr = BASE | 32'h020; pwdata = 32'hBEEF;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; psel = 0; penable = 0;
    exp_proto = 0;
    mdl_wait = 4'd2;
    @(posedge clk); #1;
    xfer(0, 12'hFF8, 0, rd, er, n);
    check("t6_wait_reset", rd, 2);
    check("t6_cycles", n, 3);
    xfer(0, 12'h020, 0, rd, er, n);
    check("t6_no_commit", rd, old);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
